// File: rtl/int_res_addr_gen_pkg.sv
//==============================================================================
// Module  : int_res_addr_gen_pkg
// Brief   : Shared types and bank geometry for the intermediate-result
//           address sequencer and the memory interface bank decoder.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package int_res_addr_gen_pkg;

  localparam int CIM_INT_RES_NUM_BANKS          = 4;
  localparam int CIM_INT_RES_BANK_SIZE_NUM_WORD = 14336;
  localparam int CIM_INT_RES_NUM_REGIONS        = 19;
  localparam int CIM_INT_RES_MAX_DIM            = 64;

  typedef logic [$clog2(CIM_INT_RES_NUM_BANKS)-1:0]   IntResBankIdx_t;
  typedef logic [$clog2(CIM_INT_RES_NUM_REGIONS)-1:0] RegionIdx_t;

  typedef enum logic {HORIZONTAL = 1'b0, VERTICAL = 1'b1}        Direction_t;
  typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1}  DataWidth_t;
  typedef enum logic {FIRST_HALF = 1'b0, SECOND_HALF = 1'b1}     HalfSelect_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } AddrGenState_t;

  // First flat word of bank idx; bank boundaries are multiples of the bank size.
  function automatic int bank_boundary(input int idx, input int bank_size);
    return idx * bank_size;
  endfunction

  localparam int INT_RES_BANK1_BASE = bank_boundary(1, CIM_INT_RES_BANK_SIZE_NUM_WORD);
  localparam int INT_RES_BANK2_BASE = bank_boundary(2, CIM_INT_RES_BANK_SIZE_NUM_WORD);
  localparam int INT_RES_BANK3_BASE = bank_boundary(3, CIM_INT_RES_BANK_SIZE_NUM_WORD);
  localparam int INT_RES_MEM_TOP    = bank_boundary(CIM_INT_RES_NUM_BANKS,
                                                    CIM_INT_RES_BANK_SIZE_NUM_WORD);

endpackage

`default_nettype wire

// File: rtl/int_res_bank_decoder.sv
//==============================================================================
// Module  : int_res_bank_decoder
// Brief   : Combinational flat address -> (bank, bank_addr) decode by priority
//           compare against constant bank boundaries.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module int_res_bank_decoder
  import int_res_addr_gen_pkg::*;
#(
  parameter int NUM_BANKS          = CIM_INT_RES_NUM_BANKS,
  parameter int BANK_SIZE_NUM_WORD = CIM_INT_RES_BANK_SIZE_NUM_WORD,
  parameter int FLAT_W             = $clog2(NUM_BANKS * BANK_SIZE_NUM_WORD) + 1,
  parameter int BANK_W             = $clog2(NUM_BANKS),
  parameter int BANK_ADDR_W        = $clog2(BANK_SIZE_NUM_WORD)
) (
  input  logic [FLAT_W-1:0]      flat,
  output logic [BANK_W-1:0]      bank,
  output logic [BANK_ADDR_W-1:0] bank_addr
);

  // Highest boundary not above flat wins; addresses past the top alias into the last bank.
  always_comb begin
    bank      = '0;
    bank_addr = BANK_ADDR_W'(flat);
    for (int i = 1; i < NUM_BANKS; i++) begin
      if (flat >= FLAT_W'(bank_boundary(i, BANK_SIZE_NUM_WORD))) begin
        bank      = BANK_W'(i);
        bank_addr = BANK_ADDR_W'(flat - FLAT_W'(bank_boundary(i, BANK_SIZE_NUM_WORD)));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_res_addr_gen.sv
//==============================================================================
// Module  : int_res_addr_gen
// Brief   : 2D walk address sequencer for the intermediate-result memory with a
//           programmable region base table. Optional range check enabled by
//           macro INT_RES_ADDR_RANGE_CHECK_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module int_res_addr_gen
  import int_res_addr_gen_pkg::*;
#(
  parameter int NUM_BANKS          = CIM_INT_RES_NUM_BANKS,
  parameter int BANK_SIZE_NUM_WORD = CIM_INT_RES_BANK_SIZE_NUM_WORD,
  parameter int NUM_REGIONS        = CIM_INT_RES_NUM_REGIONS,
  parameter int MAX_DIM            = CIM_INT_RES_MAX_DIM
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            cfg_wr_en,
  input  logic [$clog2(NUM_REGIONS)-1:0]                  cfg_region,
  input  logic [$clog2(NUM_BANKS*BANK_SIZE_NUM_WORD)-1:0] cfg_base,
  input  logic                                            start,
  input  logic [$clog2(NUM_REGIONS)-1:0]                  region,
  input  Direction_t                                      direction,
  input  DataWidth_t                                      width,
  input  logic [$clog2(MAX_DIM+1)-1:0]                    num_rows,
  input  logic [$clog2(MAX_DIM+1)-1:0]                    num_cols,
  input  logic [$clog2(NUM_BANKS*BANK_SIZE_NUM_WORD)-1:0] row_stride,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [$clog2(NUM_BANKS)-1:0]                    out_bank,
  output logic [$clog2(BANK_SIZE_NUM_WORD)-1:0]           out_bank_addr,
  output HalfSelect_t                                     out_half,
  output logic                                            out_last,
  output logic                                            range_err
);

  localparam int MEM_WORDS   = NUM_BANKS * BANK_SIZE_NUM_WORD;
  localparam int ADDR_W      = $clog2(MEM_WORDS);
  localparam int DIM_W       = $clog2(MAX_DIM + 1);
  localparam int REGION_W    = $clog2(NUM_REGIONS);
  localparam int BANK_W      = $clog2(NUM_BANKS);
  localparam int BANK_ADDR_W = $clog2(BANK_SIZE_NUM_WORD);

  AddrGenState_t         state_q, state_d;
  logic [ADDR_W-1:0]     table_q [NUM_REGIONS];
  logic [ADDR_W-1:0]     table_d [NUM_REGIONS];
  logic [ADDR_W-1:0]     base_q, base_d, stride_q, stride_d;
  Direction_t            dir_q, dir_d;
  DataWidth_t            width_q, width_d;
  logic [DIM_W-1:0]      rows_q, rows_d, cols_q, cols_d, r_q, r_d, c_q, c_d;
  logic [ADDR_W:0]       row_base_q, row_base_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [BANK_W-1:0]     out_bank_q, out_bank_d;
  logic [BANK_ADDR_W-1:0] out_bank_addr_q, out_bank_addr_d;
  HalfSelect_t           out_half_q, out_half_d;
  logic                  range_err_q, range_err_d;

  logic                  launch, load_beat, nxt_last;
  logic [ADDR_W-1:0]     start_base, eff_base, eff_stride;
  Direction_t            eff_dir;
  DataWidth_t            eff_width;
  logic [DIM_W-1:0]      eff_rows, eff_cols, nxt_r, nxt_c;
  logic [ADDR_W:0]       nxt_row_base, elem, flat;
  HalfSelect_t           nxt_half;
  logic [BANK_W-1:0]     dec_bank, beat_bank;
  logic [BANK_ADDR_W-1:0] dec_addr, beat_addr;
  logic                  beat_oor;

  int_res_bank_decoder #(
    .NUM_BANKS          (NUM_BANKS),
    .BANK_SIZE_NUM_WORD (BANK_SIZE_NUM_WORD),
    .FLAT_W             (ADDR_W + 1),
    .BANK_W             (BANK_W),
    .BANK_ADDR_W        (BANK_ADDR_W)
  ) u_decoder (
    .flat      (flat),
    .bank      (dec_bank),
    .bank_addr (dec_addr)
  );

  // Walk parameters come straight from the inputs on the launch cycle, latched copies afterwards.
  always_comb begin
    launch     = (state_q == IDLE) && start;
    start_base = (region < REGION_W'(NUM_REGIONS)) ? table_q[region] : '0;
    eff_base   = launch ? start_base : base_q;
    eff_stride = launch ? row_stride : stride_q;
    eff_dir    = launch ? direction  : dir_q;
    eff_width  = launch ? width      : width_q;
    eff_rows   = launch ? num_rows   : rows_q;
    eff_cols   = launch ? num_cols   : cols_q;

    nxt_r        = r_q;
    nxt_c        = c_q;
    nxt_half     = out_half_q;
    nxt_row_base = row_base_q;
    if (launch) begin
      nxt_r        = '0;
      nxt_c        = '0;
      nxt_half     = FIRST_HALF;
      nxt_row_base = '0;
    end else if (eff_width == DOUBLE_WIDTH && out_half_q == FIRST_HALF) begin
      nxt_half = SECOND_HALF;
    end else begin
      nxt_half = FIRST_HALF;
      if (eff_dir == HORIZONTAL) begin
        if (c_q == eff_cols - DIM_W'(1)) begin
          nxt_c        = '0;
          nxt_r        = r_q + DIM_W'(1);
          nxt_row_base = row_base_q + {1'b0, eff_stride};
        end else begin
          nxt_c = c_q + DIM_W'(1);
        end
      end else begin
        if (r_q == eff_rows - DIM_W'(1)) begin
          nxt_r        = '0;
          nxt_row_base = '0;
          nxt_c        = c_q + DIM_W'(1);
        end else begin
          nxt_r        = r_q + DIM_W'(1);
          nxt_row_base = row_base_q + {1'b0, eff_stride};
        end
      end
    end

    elem     = nxt_row_base + (ADDR_W + 1)'(nxt_c);
    flat     = {1'b0, eff_base}
             + ((eff_width == DOUBLE_WIDTH) ? {elem[ADDR_W-1:0], 1'b0} : elem)
             + {{ADDR_W{1'b0}}, nxt_half == SECOND_HALF};
    nxt_last = (nxt_r == eff_rows - DIM_W'(1)) && (nxt_c == eff_cols - DIM_W'(1)) &&
               (eff_width == SINGLE_WIDTH || nxt_half == SECOND_HALF);

`ifdef INT_RES_ADDR_RANGE_CHECK_EN
    beat_oor  = flat >= (ADDR_W + 1)'(MEM_WORDS);
    beat_bank = beat_oor ? BANK_W'(NUM_BANKS - 1) : dec_bank;
    beat_addr = beat_oor ? BANK_ADDR_W'(BANK_SIZE_NUM_WORD - 1) : dec_addr;
`else
    beat_oor  = 1'b0;
    beat_bank = dec_bank;
    beat_addr = dec_addr;
`endif
  end

  always_comb begin
    table_d = table_q;
    if (cfg_wr_en && cfg_region < REGION_W'(NUM_REGIONS)) table_d[cfg_region] = cfg_base;

    state_d         = state_q;
    base_d          = base_q;
    stride_d        = stride_q;
    dir_d           = dir_q;
    width_d         = width_q;
    rows_d          = rows_q;
    cols_d          = cols_q;
    r_d             = r_q;
    c_d             = c_q;
    row_base_d      = row_base_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    out_bank_d      = out_bank_q;
    out_bank_addr_d = out_bank_addr_q;
    out_half_d      = out_half_q;
    range_err_d     = range_err_q;
    load_beat       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = start_base;
          stride_d = row_stride;
          dir_d    = direction;
          width_d  = width;
          rows_d   = num_rows;
          cols_d   = num_cols;
          if (num_rows == '0 || num_cols == '0) begin
            state_d = DONE;
          end else begin
            state_d   = RUN;
            load_beat = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_beat) begin
      r_d             = nxt_r;
      c_d             = nxt_c;
      row_base_d      = nxt_row_base;
      out_valid_d     = 1'b1;
      out_last_d      = nxt_last;
      out_bank_d      = beat_bank;
      out_bank_addr_d = beat_addr;
      out_half_d      = nxt_half;
      if (beat_oor) range_err_d = 1'b1;
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      table_q         <= '{default: '0};
      base_q          <= '0;
      stride_q        <= '0;
      dir_q           <= HORIZONTAL;
      width_q         <= SINGLE_WIDTH;
      rows_q          <= '0;
      cols_q          <= '0;
      r_q             <= '0;
      c_q             <= '0;
      row_base_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_bank_q      <= '0;
      out_bank_addr_q <= '0;
      out_half_q      <= FIRST_HALF;
      range_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      table_q         <= table_d;
      base_q          <= base_d;
      stride_q        <= stride_d;
      dir_q           <= dir_d;
      width_q         <= width_d;
      rows_q          <= rows_d;
      cols_q          <= cols_d;
      r_q             <= r_d;
      c_q             <= c_d;
      row_base_q      <= row_base_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      out_bank_q      <= out_bank_d;
      out_bank_addr_q <= out_bank_addr_d;
      out_half_q      <= out_half_d;
      range_err_q     <= range_err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_bank      = out_bank_q;
  assign out_bank_addr = out_bank_addr_q;
  assign out_half      = out_half_q;
  assign range_err     = range_err_q;

endmodule

`default_nettype wire

// File: tb/tb_int_res_addr_gen.sv
//==============================================================================
// Module  : tb_int_res_addr_gen
// Brief   : Directed self-checking bench for int_res_addr_gen.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_int_res_addr_gen;
  import int_res_addr_gen_pkg::*;

  localparam int BS = 14336;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_en;
  logic [4:0]  cfg_region;
  logic [15:0] cfg_base;
  logic        start;
  logic [4:0]  region;
  Direction_t  direction;
  DataWidth_t  width;
  logic [6:0]  num_rows, num_cols;
  logic [15:0] row_stride;
  logic        busy, done, out_valid, out_ready, out_last, range_err;
  logic [1:0]  out_bank;
  logic [13:0] out_bank_addr;
  HalfSelect_t out_half;

  int errors = 0;
  int checks = 0;

  logic [1:0]  cap_bank[$];
  logic [13:0] cap_addr[$];
  HalfSelect_t cap_half[$];
  logic        cap_last[$];
  logic        cap_rerr[$];

  always #5 clk = ~clk;

  int_res_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_region(cfg_region),
    .cfg_base(cfg_base), .start(start), .region(region), .direction(direction),
    .width(width), .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_bank(out_bank), .out_bank_addr(out_bank_addr), .out_half(out_half),
    .out_last(out_last), .range_err(range_err)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic program_base(input int rg, input int base);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_region = 5'(rg); cfg_base = 16'(base);
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic launch(input int rg, input Direction_t d, input DataWidth_t w,
                        input int rows, input int cols, input int stride);
    @(negedge clk);
    start = 1'b1; region = 5'(rg); direction = d; width = w;
    num_rows = 7'(rows); num_cols = 7'(cols); row_stride = 16'(stride);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accept every beat until the last one is seen; returns at the negedge showing it.
  task automatic collect(input int budget, output bit timed_out);
    cap_bank.delete(); cap_addr.delete(); cap_half.delete();
    cap_last.delete(); cap_rerr.delete();
    timed_out = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (out_valid) begin
        cap_bank.push_back(out_bank); cap_addr.push_back(out_bank_addr);
        cap_half.push_back(out_half); cap_last.push_back(out_last);
        cap_rerr.push_back(range_err);
        if (out_last) begin
          timed_out = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid, out_last, range_err} !== 5'b0)
      $display("FAIL reset_flags: got busy/done/valid/last/rerr=%b, want 00000",
               {busy, done, out_valid, out_last, range_err});
    if ({busy, done, out_valid, out_last, range_err} !== 5'b0) errors++;
    checks++;
    if (out_bank !== 2'd0 || out_bank_addr !== 14'd0 || out_half !== FIRST_HALF) begin
      errors++;
      $display("FAIL reset_beat: got bank=%0d addr=%0d half=%0d, want 0 0 0",
               out_bank, out_bank_addr, out_half);
    end
  endtask

  task automatic test_horizontal_single();
    bit to;
    int exp_addr[6] = '{5664, 5665, 5666, 5728, 5729, 5730};
    program_base(4, 20000);
    launch(4, HORIZONTAL, SINGLE_WIDTH, 2, 3, 64);
    collect(50, to);
    checks++;
    if (to || cap_addr.size() != 6) begin
      errors++;
      $display("FAIL hsingle_count: got %0d beats timeout=%0d, want 6", cap_addr.size(), to);
    end
    for (int i = 0; i < cap_addr.size() && i < 6; i++) begin
      checks++;
      if (cap_bank[i] !== 2'd1 || cap_addr[i] !== 14'(exp_addr[i]) || cap_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL hsingle_beat%0d: got bank=%0d addr=%0d last=%0d, want bank=1 addr=%0d last=%0d",
                 i, cap_bank[i], cap_addr[i], cap_last[i], exp_addr[i], i == 5);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hsingle_done: got done=%0d valid=%0d, want done=1 valid=0", done, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hsingle_idle: got done=%0d busy=%0d, want 0 0", done, busy);
    end
  endtask

  task automatic test_vertical_double();
    bit to;
    int exp_addr[8] = '{0, 1, 20, 21, 2, 3, 22, 23};
    program_base(2, 0);
    launch(2, VERTICAL, DOUBLE_WIDTH, 2, 2, 10);
    collect(50, to);
    checks++;
    if (to || cap_addr.size() != 8) begin
      errors++;
      $display("FAIL vdouble_count: got %0d beats timeout=%0d, want 8", cap_addr.size(), to);
    end
    for (int i = 0; i < cap_addr.size() && i < 8; i++) begin
      checks++;
      if (cap_bank[i] !== 2'd0 || cap_addr[i] !== 14'(exp_addr[i]) ||
          cap_half[i] !== HalfSelect_t'(i % 2) || cap_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL vdouble_beat%0d: got bank=%0d addr=%0d half=%0d last=%0d, want 0 %0d %0d %0d",
                 i, cap_bank[i], cap_addr[i], cap_half[i], cap_last[i], exp_addr[i], i % 2, i == 7);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bank_crossing();
    bit to;
    program_base(7, 14335);
    launch(7, HORIZONTAL, SINGLE_WIDTH, 1, 2, 0);
    collect(50, to);
    checks++;
    if (to || cap_addr.size() != 2 || cap_bank[0] !== 2'd0 || cap_addr[0] !== 14'd14335 ||
        cap_bank[1] !== 2'd1 || cap_addr[1] !== 14'd0) begin
      errors++;
      $display("FAIL bank_cross: got %0d beats first=(%0d,%0d) second=(%0d,%0d), want (0,14335) (1,0)",
               cap_addr.size(), cap_bank.size() > 0 ? cap_bank[0] : 2'd0,
               cap_addr.size() > 0 ? cap_addr[0] : 14'd0,
               cap_bank.size() > 1 ? cap_bank[1] : 2'd0,
               cap_addr.size() > 1 ? cap_addr[1] : 14'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cfg_collision();
    bit to;
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_region = 5'd4; cfg_base = 16'd30000;
    start = 1'b1; region = 5'd4; direction = HORIZONTAL; width = SINGLE_WIDTH;
    num_rows = 7'd1; num_cols = 7'd1; row_stride = 16'd0;
    @(negedge clk);
    cfg_wr_en = 1'b0; start = 1'b0;
    collect(20, to);
    checks++;
    if (to || cap_bank[0] !== 2'd1 || cap_addr[0] !== 14'd5664) begin
      errors++;
      $display("FAIL cfg_old_value: got (%0d,%0d) timeout=%0d, want (1,5664)",
               cap_bank.size() > 0 ? cap_bank[0] : 2'd0, cap_addr.size() > 0 ? cap_addr[0] : 14'd0, to);
    end
    repeat (2) @(negedge clk);
    launch(4, HORIZONTAL, SINGLE_WIDTH, 1, 1, 0);
    collect(20, to);
    checks++;
    if (to || cap_bank[0] !== 2'd2 || cap_addr[0] !== 14'd1328) begin
      errors++;
      $display("FAIL cfg_new_value: got (%0d,%0d) timeout=%0d, want (2,1328)",
               cap_bank.size() > 0 ? cap_bank[0] : 2'd0, cap_addr.size() > 0 ? cap_addr[0] : 14'd0, to);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int exp_flat[$];
    bit held;
    logic [1:0] hb;
    logic [13:0] ha;
    HalfSelect_t hh;
    logic hl;
    logic rdy;
    int n;
    bit got_last;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        for (int h = 0; h < 2; h++)
          exp_flat.push_back(100 + 2 * (r * 5 + c) + h);
    program_base(5, 100);
    out_ready = 1'b0;
    launch(5, HORIZONTAL, DOUBLE_WIDTH, 3, 2, 5);
    held = 1'b0; n = 0; got_last = 1'b0;
    hb = '0; ha = '0; hh = FIRST_HALF; hl = 1'b0;
    for (int k = 0; k < 300 && !got_last; k++) begin
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_bank !== hb || out_bank_addr !== ha ||
            out_half !== hh || out_last !== hl) begin
          errors++;
          $display("FAIL bp_stable: got valid=%0d (%0d,%0d,%0d,%0d), want held (%0d,%0d,%0d,%0d)",
                   out_valid, out_bank, out_bank_addr, out_half, out_last, hb, ha, hh, hl);
        end
      end
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      held = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          checks++;
          if (n >= exp_flat.size() || out_bank !== 2'(exp_flat[n] / BS) ||
              out_bank_addr !== 14'(exp_flat[n] % BS) || out_half !== HalfSelect_t'(n % 2) ||
              out_last !== (n == exp_flat.size() - 1)) begin
            errors++;
            $display("FAIL bp_beat%0d: got (%0d,%0d,%0d,%0d), want flat %0d",
                     n, out_bank, out_bank_addr, out_half, out_last,
                     n < exp_flat.size() ? exp_flat[n] : -1);
          end
          n++;
          got_last = out_last;
        end else begin
          held = 1'b1;
          hb = out_bank; ha = out_bank_addr; hh = out_half; hl = out_last;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 12 || !got_last) begin
      errors++;
      $display("FAIL bp_count: got %0d beats last_seen=%0d, want 12", n, got_last);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty_walk();
    launch(0, HORIZONTAL, SINGLE_WIDTH, 3, 0, 1);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: got done=%0d valid=%0d, want done=1 valid=0", done, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: got done=%0d busy=%0d valid=%0d, want 0 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    out_ready = 1'b0;
    launch(4, HORIZONTAL, SINGLE_WIDTH, 1, 3, 1);
    launch(5, VERTICAL, DOUBLE_WIDTH, 2, 2, 10);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_bank !== 2'd2 ||
        out_bank_addr !== 14'd1328 || out_half !== FIRST_HALF) begin
      errors++;
      $display("FAIL busy_hold: got busy=%0d valid=%0d (%0d,%0d,%0d), want 1 1 (2,1328,0)",
               busy, out_valid, out_bank, out_bank_addr, out_half);
    end
    collect(50, to);
    checks++;
    if (to || cap_addr.size() != 3 || cap_addr[1] !== 14'd1329 || cap_addr[2] !== 14'd1330 ||
        cap_bank[2] !== 2'd2 || cap_half[2] !== FIRST_HALF) begin
      errors++;
      $display("FAIL busy_ignored: got %0d beats timeout=%0d, want 3 beats at bank 2 addr 1328..1330",
               cap_addr.size(), to);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    bit to;
    out_ready = 1'b1;
    launch(4, HORIZONTAL, SINGLE_WIDTH, 2, 3, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_last !== 1'b0 ||
        out_bank_addr !== 14'd0 || out_bank !== 2'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%0d valid=%0d done=%0d last=%0d (%0d,%0d), want all 0",
               busy, out_valid, done, out_last, out_bank, out_bank_addr);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_done%0d: got done=%0d busy=%0d, want 0 0", k, done, busy);
      end
    end
    launch(4, HORIZONTAL, SINGLE_WIDTH, 1, 1, 0);
    collect(20, to);
    checks++;
    if (to || cap_bank[0] !== 2'd0 || cap_addr[0] !== 14'd0) begin
      errors++;
      $display("FAIL midrst_table: got (%0d,%0d) timeout=%0d, want (0,0)",
               cap_bank.size() > 0 ? cap_bank[0] : 2'd0, cap_addr.size() > 0 ? cap_addr[0] : 14'd0, to);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_range();
    bit to;
    logic [13:0] exp_addr1;
    logic exp_rerr;
`ifdef INT_RES_ADDR_RANGE_CHECK_EN
    exp_addr1 = 14'd14335;
    exp_rerr  = 1'b1;
`else
    exp_addr1 = 14'd14336;
    exp_rerr  = 1'b0;
`endif
    program_base(6, 57343);
    launch(6, HORIZONTAL, SINGLE_WIDTH, 1, 2, 0);
    collect(20, to);
    checks++;
    if (to || cap_addr.size() != 2 || cap_bank[0] !== 2'd3 || cap_addr[0] !== 14'd14335 ||
        cap_rerr[0] !== 1'b0) begin
      errors++;
      $display("FAIL range_beat0: got %0d beats timeout=%0d, want (3,14335) rerr=0", cap_addr.size(), to);
    end
    checks++;
    if (cap_addr.size() < 2 || cap_bank[1] !== 2'd3 || cap_addr[1] !== exp_addr1 ||
        cap_rerr[1] !== exp_rerr) begin
      errors++;
      $display("FAIL range_beat1: got (%0d,%0d) rerr=%0d, want (3,%0d) rerr=%0d",
               cap_bank.size() > 1 ? cap_bank[1] : 2'd0, cap_addr.size() > 1 ? cap_addr[1] : 14'd0,
               cap_rerr.size() > 1 ? cap_rerr[1] : 1'b0, exp_addr1, exp_rerr);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (range_err !== exp_rerr) begin
      errors++;
      $display("FAIL range_sticky: got %0d, want %0d", range_err, exp_rerr);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_clear: got %0d, want 0", range_err);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_region = '0; cfg_base = '0;
    start = 1'b0; region = '0; direction = HORIZONTAL; width = SINGLE_WIDTH;
    num_rows = '0; num_cols = '0; row_stride = '0; out_ready = 1'b1;
    test_reset();
    test_horizontal_single();
    test_vertical_double();
    test_bank_crossing();
    test_cfg_collision();
    test_backpressure();
    test_empty_walk();
    test_start_while_busy();
    test_reset_mid_walk();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
